// File: rtl/flux_pkg.sv
// Shared definitions for the multi-flux FIFO front end.
// Word layout is {tag, payload}; helpers pack and split it.
package flux_pkg;

    localparam int DEF_FLUX       = 2;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_DATA_WIDTH = 7;

    function automatic int tag_width(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    localparam int DEF_TAG_WIDTH = tag_width(DEF_FLUX);

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] payload;
    } flux_word_t;

    function automatic flux_word_t make_word(
        input logic [DEF_TAG_WIDTH-1:0]  tag,
        input logic [DEF_DATA_WIDTH-1:0] payload
    );
        flux_word_t w;
        w.tag     = tag;
        w.payload = payload;
        return w;
    endfunction

    function automatic logic [DEF_TAG_WIDTH-1:0] word_tag(
        input flux_word_t w
    );
        return w.tag;
    endfunction

    function automatic logic [DEF_DATA_WIDTH-1:0] word_payload(
        input flux_word_t w
    );
        return w.payload;
    endfunction

endpackage

// File: rtl/flux_tag_merger_if.sv
// Stream inputs, FIFO write port and credit snoop bundle.
// slave = merger side, master = stream sources / FIFO side.
interface flux_tag_merger_if
    import flux_pkg::*;
#(
    parameter int FLUX         = DEF_FLUX,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MAX_PER_FLUX = 4
);
    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int CNT_WIDTH = $clog2(MAX_PER_FLUX + 1);

    logic [FLUX-1:0]                 in_valid;
    logic [FLUX*DATA_WIDTH-1:0]      in_data;
    logic [FLUX-1:0]                 in_ready;
    logic                            fifo_full;
    logic [FLUX-1:0]                 fifo_empty;
    logic [FLUX-1:0]                 fifo_rd;
    logic                            fifo_wr;
    logic [DATA_WIDTH+TAG_WIDTH-1:0] fifo_datain;
    logic [FLUX*CNT_WIDTH-1:0]       credit_cnt;

    modport slave (
        input  in_valid, in_data, fifo_full,
        input  fifo_empty, fifo_rd,
        output in_ready, fifo_wr, fifo_datain,
        output credit_cnt
    );

    modport master (
        output in_valid, in_data, fifo_full,
        output fifo_empty, fifo_rd,
        input  in_ready, fifo_wr, fifo_datain,
        input  credit_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter, one-hot grant.
// Search starts at ptr and wraps; the pointer lives in the parent.
module rr_arbiter
    import flux_pkg::*;
#(
    parameter int N = 2,
    localparam int PW = tag_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk from ptr, granting the first requester found.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = ptr;
        for (int o = 0; o < N; o++) begin
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
            idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/flux_tag_merger.sv
// Multi-flux FIFO write front end: per-stream hold registers,
// round-robin tagging merger and per-flux occupancy credits.
module flux_tag_merger
    import flux_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int FLUX         = DEF_FLUX,
    parameter int MAX_PER_FLUX = 4,
    parameter int DEPTH        = DEF_DEPTH
) (
    input  logic             ck,
    input  logic             rst,
    flux_tag_merger_if.slave bus
);

    localparam int TAG_WIDTH = tag_width(FLUX);
    localparam int CNT_WIDTH = $clog2(MAX_PER_FLUX + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX =
        CNT_WIDTH'(MAX_PER_FLUX);

    if (FLUX < 2 || MAX_PER_FLUX > DEPTH) begin : g_bad_cfg
        $error("flux_tag_merger: bad FLUX/MAX_PER_FLUX");
    end

    logic                  hold_valid [FLUX];
    logic [DATA_WIDTH-1:0] hold_data  [FLUX];
    logic [CNT_WIDTH-1:0]  cnt        [FLUX];
    logic [TAG_WIDTH-1:0]  rr_ptr;

    logic [FLUX-1:0] elig;
    logic [FLUX-1:0] grant;
    logic [FLUX-1:0] ready;
    logic [FLUX-1:0] accept;
    logic [FLUX-1:0] inc;
    logic [FLUX-1:0] dec;

    logic [TAG_WIDTH-1:0]            gidx;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] datain;

    for (genvar i = 0; i < FLUX; i++) begin : g_flux
        assign elig[i] = hold_valid[i]
                       & (cnt[i] < CNT_MAX)
                       & ~bus.fifo_full;
        assign ready[i]  = rst & (~hold_valid[i] | grant[i]);
        assign accept[i] = bus.in_valid[i] & ready[i];
        assign inc[i]    = grant[i];
        assign dec[i]    = bus.fifo_rd[i] & ~bus.fifo_empty[i];
        assign bus.credit_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];

        // Hold register: load on accept, empty when granted alone.
        always_ff @(posedge ck or negedge rst) begin
            if (!rst) begin
                hold_valid[i] <= 1'b0;
                hold_data[i]  <= '0;
            end else if (accept[i]) begin
                hold_valid[i] <= 1'b1;
                hold_data[i]  <=
                    bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (grant[i]) begin
                hold_valid[i] <= 1'b0;
            end
        end

        // Occupancy credit: +1 per write, -1 per real read.
        always_ff @(posedge ck or negedge rst) begin
            if (!rst) begin
                cnt[i] <= '0;
            end else if (inc[i] && !dec[i]) begin
                cnt[i] <= cnt[i] + 1'b1;
            end else if (dec[i] && !inc[i] && cnt[i] != '0) begin
                cnt[i] <= cnt[i] - 1'b1;
            end
        end

        // A read with no outstanding entry breaks the protocol.
        always @(posedge ck) begin
            if (rst) begin
                assert (!(dec[i] && !inc[i] && cnt[i] == '0));
            end
        end
    end

    rr_arbiter #(
        .N     (FLUX)
    ) u_arb (
        .req   (elig),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Select the granted hold word and prefix its flux tag.
    always_comb begin
        gidx   = '0;
        datain = '0;
        for (int i = 0; i < FLUX; i++) begin
            if (grant[i]) begin
                gidx   = TAG_WIDTH'(i);
                datain = {TAG_WIDTH'(i), hold_data[i]};
            end
        end
    end

    // Round-robin pointer moves past the flux just served.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (gidx == TAG_WIDTH'(FLUX - 1))
                    ? '0 : gidx + 1'b1;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.fifo_wr     = |grant;
    assign bus.fifo_datain = datain;

endmodule

// File: tb/tb_flux_tag_merger.sv
// Scoreboard bench for flux_tag_merger: directed stream vectors,
// expected FIFO words queued at stimulus, popped by a monitor.
module tb_flux_tag_merger;
    import flux_pkg::*;

    logic ck;
    logic rst;

    flux_tag_merger_if #(
        .FLUX         (2),
        .DATA_WIDTH   (7),
        .MAX_PER_FLUX (4)
    ) bus ();

    flux_tag_merger #(
        .DATA_WIDTH   (7),
        .FLUX         (2),
        .MAX_PER_FLUX (4),
        .DEPTH        (8)
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    flux_word_t exp_q [$];
    logic [6:0] q0 [$];
    logic [6:0] q1 [$];

    logic       v0, v1;
    logic [6:0] d0, d1;
    logic [1:0] acc;

    assign bus.in_valid = {v1, v0};
    assign bus.in_data  = {d1, d0};

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge ck);
        #1;
    endtask

    task automatic wait_drain(input int budget, output int k);
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words missing after %0d cycles",
                     exp_q.size(), k);
            exp_q.delete();
        end
    endtask

    // Monitor: compare each FIFO write with the scoreboard head.
    initial begin
        flux_word_t e;
        acc = 2'b00;
        forever begin
            @(negedge ck);
            acc = bus.in_valid & bus.in_ready;
            if (bus.fifo_wr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr: got %0h want none",
                             bus.fifo_datain);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("wr_tag%0d", word_tag(e)),
                        32'(bus.fifo_datain), 32'(e));
                end
            end else begin
                chk("idle_datain", 32'(bus.fifo_datain), 32'h0);
            end
        end
    end

    // Stream 0 source: present queue head until accepted.
    initial begin
        v0 = 1'b0;
        d0 = '0;
        forever begin
            @(posedge ck);
            #2;
            if (acc[0] && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                v0 = 1'b1;
                d0 = q0[0];
            end else begin
                v0 = 1'b0;
            end
        end
    end

    // Stream 1 source.
    initial begin
        v1 = 1'b0;
        d1 = '0;
        forever begin
            @(posedge ck);
            #2;
            if (acc[1] && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                v1 = 1'b1;
                d1 = q1[0];
            end else begin
                v1 = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst            = 1'b0;
        bus.fifo_full  = 1'b0;
        bus.fifo_empty = 2'b11;
        bus.fifo_rd    = 2'b00;
        step(2);
        chk("rst_wr", 32'(bus.fifo_wr), 32'h0);
        chk("rst_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_cnt", 32'(bus.credit_cnt), 32'h0);
        chk("rst_datain", 32'(bus.fifo_datain), 32'h0);
        rst = 1'b1;
        step();
        chk("ready_after_rst", 32'(bus.in_ready), 32'h3);

        // Single stream word on flux 0.
        q0.push_back(7'h15);
        exp_q.push_back(make_word(1'b0, 7'h15));
        wait_drain(10, k);
        chk("single_cnt", 32'(bus.credit_cnt), 32'o01);
        chk("single_ready0", 32'(bus.in_ready[0]), 32'h1);
        bus.fifo_rd    = 2'b01;
        bus.fifo_empty = 2'b10;
        step();
        bus.fifo_rd    = 2'b00;
        bus.fifo_empty = 2'b11;
        step();
        chk("single_cnt_ret", 32'(bus.credit_cnt), 32'h0);

        // Fairness: pointer is 1 after the flux-0 write.
        for (int i = 1; i <= 4; i++) begin
            q0.push_back(7'(i));
            q1.push_back(7'(8'h40 + i));
        end
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(make_word(1'b1, 7'(8'h40 + i)));
            exp_q.push_back(make_word(1'b0, 7'(i)));
        end
        wait_drain(40, k);
        chk("fair_cycles", 32'(k), 32'd9);
        chk("fair_cnt", 32'(bus.credit_cnt), 32'o44);
        bus.fifo_rd    = 2'b11;
        bus.fifo_empty = 2'b00;
        step(4);
        bus.fifo_rd    = 2'b00;
        bus.fifo_empty = 2'b11;
        step();
        chk("fair_cnt_ret", 32'(bus.credit_cnt), 32'h0);

        // Credit limit on flux 1.
        for (int i = 1; i <= 6; i++) q1.push_back(7'(8'h50 + i));
        for (int i = 1; i <= 4; i++)
            exp_q.push_back(make_word(1'b1, 7'(8'h50 + i)));
        wait_drain(30, k);
        step(3);
        chk("lim_wr", 32'(bus.fifo_wr), 32'h0);
        chk("lim_ready1", 32'(bus.in_ready[1]), 32'h0);
        chk("lim_cnt", 32'(bus.credit_cnt), 32'o40);
        exp_q.push_back(make_word(1'b1, 7'h55));
        bus.fifo_rd    = 2'b10;
        bus.fifo_empty = 2'b01;
        step();
        bus.fifo_rd    = 2'b00;
        bus.fifo_empty = 2'b11;
        wait_drain(10, k);
        step(3);
        chk("lim_cnt2", 32'(bus.credit_cnt), 32'o40);
        chk("lim_ready1b", 32'(bus.in_ready[1]), 32'h0);

        // Full back-pressure with both holds valid, pointer at 0.
        bus.fifo_full  = 1'b1;
        bus.fifo_rd    = 2'b10;
        bus.fifo_empty = 2'b01;
        step(4);
        bus.fifo_rd    = 2'b00;
        bus.fifo_empty = 2'b11;
        chk("full_cnt_ret", 32'(bus.credit_cnt), 32'h0);
        q0.push_back(7'h0A);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_wr", 32'(bus.fifo_wr), 32'h0);
            chk("full_ready", 32'(bus.in_ready), 32'h0);
        end
        exp_q.push_back(make_word(1'b0, 7'h0A));
        exp_q.push_back(make_word(1'b1, 7'h56));
        bus.fifo_full = 1'b0;
        wait_drain(10, k);
        step();
        chk("full_cnt", 32'(bus.credit_cnt), 32'o11);
        bus.fifo_rd    = 2'b11;
        bus.fifo_empty = 2'b00;
        step();
        bus.fifo_rd    = 2'b00;
        bus.fifo_empty = 2'b11;
        step();
        chk("full_cnt_ret2", 32'(bus.credit_cnt), 32'h0);

        // Simultaneous increment and decrement on flux 0.
        q0.push_back(7'h11);
        q0.push_back(7'h12);
        exp_q.push_back(make_word(1'b0, 7'h11));
        exp_q.push_back(make_word(1'b0, 7'h12));
        wait_drain(15, k);
        step();
        chk("incdec_pre", 32'(bus.credit_cnt), 32'o02);
        bus.fifo_full = 1'b1;
        q0.push_back(7'h13);
        step(3);
        exp_q.push_back(make_word(1'b0, 7'h13));
        bus.fifo_full  = 1'b0;
        bus.fifo_rd    = 2'b01;
        bus.fifo_empty = 2'b10;
        step();
        bus.fifo_rd    = 2'b00;
        bus.fifo_empty = 2'b11;
        chk("incdec_cnt", 32'(bus.credit_cnt), 32'o02);
        wait_drain(5, k);

        // Reset between edges with both holds loaded.
        bus.fifo_full = 1'b1;
        q0.push_back(7'h21);
        q1.push_back(7'h61);
        step(3);
        chk("pre_rst_ready", 32'(bus.in_ready), 32'h0);
        rst = 1'b0;
        #1;
        chk("mid_rst_wr", 32'(bus.fifo_wr), 32'h0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'h0);
        chk("mid_rst_cnt", 32'(bus.credit_cnt), 32'h0);
        chk("mid_rst_datain", 32'(bus.fifo_datain), 32'h0);
        step(2);
        bus.fifo_full = 1'b0;
        step();
        rst = 1'b1;
        q1.push_back(7'h33);
        exp_q.push_back(make_word(1'b1, 7'h33));
        wait_drain(10, k);
        step();
        chk("post_rst_cnt", 32'(bus.credit_cnt), 32'o10);

        step(3);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flux_tag_merger.md
Name: flux_tag_merger

Overview:
- Write-side front end for the shared multi-flux FIFO: accepts FLUX independent untagged streams over valid/ready and buffers one word per stream.
- Arbitrates round-robin among the streams and prepends the flux tag in the MSBs.
- Drives the FIFO write port (wr/datain) under full back-pressure.
- Keeps per-flux occupancy credits from the FIFO read strobes, so no flux can hold more than MAX_PER_FLUX shared locations.

Parameters:
- DATA_WIDTH, 7, payload bits per stream word.
- FLUX, 2, number of streams; must be >=2.
- MAX_PER_FLUX, 4, maximum outstanding FIFO entries per flux; must be <= FIFO DEPTH.
- TAG_WIDTH, $clog2(FLUX), derived, not overridable.
- CNT_WIDTH, $clog2(MAX_PER_FLUX+1), derived.

Ports:
- ck  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  FLUX  per-stream word valid.
- in_data  in  FLUX*DATA_WIDTH  stream i payload at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  FLUX  per-stream accept.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  FLUX  FIFO per-flux empty flags.
- fifo_rd  in  FLUX  FIFO per-flux read strobes, snooped for credit return.
- fifo_wr  out  1  FIFO write strobe.
- fifo_datain  out  DATA_WIDTH+TAG_WIDTH  layout {tag, payload}; tag = flux index.
- credit_cnt  out  FLUX*CNT_WIDTH  per-flux outstanding count, for debug/verification.

Behaviour:
- Reset (rst=0, asynchronous):
  - hold_valid = 0, hold_data = 0, cnt[i] = 0, rr_ptr = 0.
  - Outputs: fifo_wr = 0, fifo_datain = 0, in_ready = 0 while rst=0.
  - Reset may assert mid-transfer; the buffered word is dropped. The FIFO must share the same reset so counts stay consistent.
- Hold stage:
  - One register per stream (hold_valid[i], hold_data[i]).
  - in_ready[i] = rst & (~hold_valid[i] | grant[i]), combinational.
  - Accept when in_valid[i] & in_ready[i]: hold loads at that edge.
  - Grant and accept in the same cycle: hold reloads and stays valid, giving 1 word/cycle/stream at best.
- Eligibility:
  - elig[i] = hold_valid[i] & (cnt[i] < MAX_PER_FLUX) & ~fifo_full.
- Arbiter:
  - Round-robin over elig, starting at rr_ptr; at most one grant per cycle.
  - After a grant to k: rr_ptr <= (k+1) mod FLUX, with wrap at FLUX-1 -> 0.
  - No grant: rr_ptr holds.
- Write port:
  - fifo_wr = |grant, combinational.
  - fifo_datain = {k[TAG_WIDTH-1:0], hold_data[k]} when granted, else 0.
  - Latency: input accepted at edge n is written to the FIFO at edge n+1 at the earliest.
- Credits, per edge:
  - inc[i] = grant[i]; dec[i] = fifo_rd[i] & ~fifo_empty[i].
  - inc & dec together: cnt unchanged.
  - inc only: cnt+1. Cannot exceed MAX_PER_FLUX, because the eligibility gate forbids it.
  - dec only: cnt-1. dec while cnt=0 is a protocol error: saturate at 0 and trigger a sim assertion.
- fifo_full=1: no grants; holds keep their data; in_ready[i] = ~hold_valid[i].
- A flux at cnt=MAX_PER_FLUX stalls only itself; other fluxes continue.
- Payload and tag are never reordered within a flux.

Decomposition:
- Shared package flux_pkg:
  - function tag_width(flux) (clog2 with minimum 1).
  - Constants DEF_FLUX=2, DEF_DEPTH=8, DEF_DATA_WIDTH=7.
  - Tag-field slice helper {tag, payload}, also used by the FIFO and downstream readers.
- One sub-module rr_arbiter:
  - Parameter N.
  - Inputs req[N], ptr; output one-hot grant[N].
  - Purely combinational; rr_ptr register stays in the parent.

Test Plan:
- Single stream:
  - Stimulus: in_valid=01, in_data[0]=7'h15 for one cycle, fifo_full=0.
  - Response: next cycle fifo_wr=1, fifo_datain=8'h15 (tag 0); cnt[0]=1; in_ready[0] stays 1.
- Fairness:
  - Stimulus: both streams valid continuously, data 7'h01.., 7'h41...
  - Response: writes alternate flux0, flux1, flux0... with tag MSB toggling each cycle, one write per cycle.
- Credit limit:
  - Stimulus: only flux1 sends 6 words, no reads.
  - Response: exactly 4 writes (cnt[1]=4), then fifo_wr=0 and in_ready[1]=0 with the hold full.
  - Stimulus: one fifo_rd[1] pulse with fifo_empty[1]=0.
  - Response: exactly one more write.
- Full back-pressure:
  - Stimulus: fifo_full=1 for 3 cycles with both holds valid.
  - Response: fifo_wr=0, hold data unchanged, rr_ptr unchanged; first write after full drops goes to rr_ptr's flux.
- Simultaneous inc/dec:
  - Stimulus: cnt[0]=2, grant[0] and fifo_rd[0] in the same cycle.
  - Response: cnt[0] stays 2.
- Reset mid-operation:
  - Stimulus: rst=0 asserted between edges while holds are valid.
  - Response: immediately fifo_wr=0, in_ready=00, credit_cnt=0; after release, first accepted word is written with correct tag.
